// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates, syncs, blanking and frame pulse.
// Define VGA_TEST_PATTERN_EN to drive 8 vertical colour bars on rgb; otherwise rgb is tied to zero.
module vga_timing_gen #(
    parameter int H_VISIBLE = 800,
    parameter int H_FRONT   = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BACK    = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FRONT   = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BACK    = 23,
    parameter bit SYNC_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        blnk,
    output logic        frame_start,
    output logic [15:0] frame_cnt,
    output logic [23:0] rgb
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_SYNC_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [10:0] r_hcount;
    logic [10:0] r_vcount;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_hblnk;
    logic        r_vblnk;
    logic        r_blnk;
    logic        r_frame_start;
    logic [15:0] r_frame_cnt;

    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_frame_wrap;
    logic [10:0] w_h_next;
    logic [10:0] w_v_next;
    logic        w_hsync_next;
    logic        w_vsync_next;
    logic        w_hblnk_next;
    logic        w_vblnk_next;
    logic        w_blnk_next;

    // Every decoded output is derived from the next position so it lines up with the counters.
    // NOTE: combinational outputs get a default before any conditional update, so no latch is inferred.
    always_comb begin
        w_h_wrap     = (r_hcount == H_LAST);
        w_v_wrap     = (r_vcount == V_LAST);
        w_frame_wrap = w_h_wrap && w_v_wrap;
        w_h_next     = w_h_wrap ? 11'd0 : r_hcount + 11'd1;
        w_v_next     = r_vcount;
        if (w_h_wrap) begin
            w_v_next = w_v_wrap ? 11'd0 : r_vcount + 11'd1;
        end
        w_hsync_next = ((w_h_next >= H_SYNC_START) && (w_h_next < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        w_vsync_next = ((w_v_next >= V_SYNC_START) && (w_v_next < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        w_hblnk_next = (w_h_next >= H_VIS);
        w_vblnk_next = (w_v_next >= V_VIS);
        w_blnk_next  = w_hblnk_next || w_vblnk_next;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from the same old values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hcount      <= '0;
            r_vcount      <= '0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_hblnk       <= 1'b0;
            r_vblnk       <= 1'b0;
            r_blnk        <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else if (en) begin
            r_hcount      <= w_h_next;
            r_vcount      <= w_v_next;
            r_hsync       <= w_hsync_next;
            r_vsync       <= w_vsync_next;
            r_hblnk       <= w_hblnk_next;
            r_vblnk       <= w_vblnk_next;
            r_blnk        <= w_blnk_next;
            r_frame_start <= w_frame_wrap;
            if (w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_VISIBLE / 8;

    logic [2:0]  w_bar;
    logic [23:0] w_rgb_next;
    logic [23:0] r_rgb;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    // Threshold compare instead of a divider: the bar index is the count of boundaries passed.
    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_h_next >= 11'(k * BAR_W)) begin
                w_bar = 3'(k);
            end
        end
        w_rgb_next = w_blnk_next ? 24'h000000 : bar_colour(w_bar);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rgb <= '0;
        end else if (en) begin
            r_rgb <= w_rgb_next;
        end
    end

    assign rgb = r_rgb;
`else
    assign rgb = 24'h000000;
`endif

    assign hcount      = r_hcount;
    assign vcount      = r_vcount;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign hblnk       = r_hblnk;
    assign vblnk       = r_vblnk;
    assign blnk        = r_blnk;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

`ifndef SYNTHESIS
    // The 11-bit counters cannot represent totals beyond 2048.
    a_total_fits : assert property (@(posedge clk) (H_TOTAL <= 2048) && (V_TOTAL <= 2048))
        else $error("vga_timing_gen: H_TOTAL=%0d or V_TOTAL=%0d exceeds 2048", H_TOTAL, V_TOTAL);
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: table vectors on a default-size instance, model-checked random run on a small one.
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
    localparam bit PAT_ON = 1'b1;
`else
    localparam bit PAT_ON = 1'b0;
`endif

    // Small raster so whole frames and random enable/reset runs stay short.
    localparam int BHV = 16, BHF = 2, BHS = 3, BHB = 3;
    localparam int BVV = 10, BVF = 1, BVS = 2, BVB = 3;
    localparam bit BPOL = 1'b0;
    localparam int BHT  = BHV + BHF + BHS + BHB;
    localparam int BTOT = BHT * (BVV + BVF + BVS + BVB);

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        bl;
        logic        fs;
        logic [15:0] fc;
        logic [23:0] rgb;
    } obs_t;

    typedef struct {
        int          adv;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        hb;
        logic [23:0] pat;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, en_a, rst_b, en_b;
    logic [10:0] a_hcount, a_vcount, b_hcount, b_vcount;
    logic        a_hsync, a_vsync, a_hblnk, a_vblnk, a_blnk, a_frame_start;
    logic        b_hsync, b_vsync, b_hblnk, b_vblnk, b_blnk, b_frame_start;
    logic [15:0] a_frame_cnt, b_frame_cnt;
    logic [23:0] a_rgb, b_rgb;

    vga_timing_gen dut_a (
        .clk(clk), .rst(rst_a), .en(en_a),
        .hcount(a_hcount), .vcount(a_vcount), .hsync(a_hsync), .vsync(a_vsync),
        .hblnk(a_hblnk), .vblnk(a_vblnk), .blnk(a_blnk), .frame_start(a_frame_start),
        .frame_cnt(a_frame_cnt), .rgb(a_rgb)
    );

    vga_timing_gen #(
        .H_VISIBLE(BHV), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
        .V_VISIBLE(BVV), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB), .SYNC_POL(BPOL)
    ) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b),
        .hcount(b_hcount), .vcount(b_vcount), .hsync(b_hsync), .vsync(b_vsync),
        .hblnk(b_hblnk), .vblnk(b_vblnk), .blnk(b_blnk), .frame_start(b_frame_start),
        .frame_cnt(b_frame_cnt), .rgb(b_rgb)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state for dut_b: linear raster position, frames seen, pulse and fresh-from-reset flags.
    int m_p, m_frames;
    bit m_fs, m_fresh;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_obs(input string tag, input obs_t act, input obs_t exp);
        check({tag, ".hcount"},      32'(act.h),   32'(exp.h));
        check({tag, ".vcount"},      32'(act.v),   32'(exp.v));
        check({tag, ".hsync"},       32'(act.hs),  32'(exp.hs));
        check({tag, ".vsync"},       32'(act.vs),  32'(exp.vs));
        check({tag, ".hblnk"},       32'(act.hb),  32'(exp.hb));
        check({tag, ".vblnk"},       32'(act.vb),  32'(exp.vb));
        check({tag, ".blnk"},        32'(act.bl),  32'(exp.bl));
        check({tag, ".frame_start"}, 32'(act.fs),  32'(exp.fs));
        check({tag, ".frame_cnt"},   32'(act.fc),  32'(exp.fc));
        check({tag, ".rgb"},         32'(act.rgb), 32'(exp.rgb));
    endtask

    function automatic obs_t obs_a();
        obs_t o;
        o.h = a_hcount; o.v = a_vcount; o.hs = a_hsync; o.vs = a_vsync;
        o.hb = a_hblnk; o.vb = a_vblnk; o.bl = a_blnk; o.fs = a_frame_start;
        o.fc = a_frame_cnt; o.rgb = a_rgb;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.h = b_hcount; o.v = b_vcount; o.hs = b_hsync; o.vs = b_vsync;
        o.hb = b_hblnk; o.vb = b_vblnk; o.bl = b_blnk; o.fs = b_frame_start;
        o.fc = b_frame_cnt; o.rgb = b_rgb;
        return o;
    endfunction

    // Bar colours by rule: red on bars 0,1,4,5; green on 0..3; blue on even bars.
    function automatic logic [23:0] bar_rgb(input int idx);
        logic [7:0] r, g, b;
        r = ((idx % 4) < 2) ? 8'hFF : 8'h00;
        g = (idx < 4)       ? 8'hFF : 8'h00;
        b = ((idx % 2) == 0) ? 8'hFF : 8'h00;
        return {r, g, b};
    endfunction

    function automatic obs_t model_b();
        obs_t o;
        int h, v;
        h = m_p % BHT;
        v = m_p / BHT;
        o.h   = 11'(h);
        o.v   = 11'(v);
        o.hs  = (h >= BHV + BHF && h < BHV + BHF + BHS) ? BPOL : !BPOL;
        o.vs  = (v >= BVV + BVF && v < BVV + BVF + BVS) ? BPOL : !BPOL;
        o.hb  = (h >= BHV);
        o.vb  = (v >= BVV);
        o.bl  = o.hb | o.vb;
        o.fs  = m_fs;
        o.fc  = 16'(m_frames);
        o.rgb = (PAT_ON && !m_fresh && !o.bl) ? bar_rgb(h / (BHV / 8)) : 24'h0;
        return o;
    endfunction

    task automatic model_reset();
        m_p = 0; m_frames = 0; m_fs = 1'b0; m_fresh = 1'b1;
    endtask

    task automatic model_step();
        m_p = (m_p + 1) % BTOT;
        m_fs = (m_p == 0);
        if (m_fs) m_frames = (m_frames + 1) % 65536;
        m_fresh = 1'b0;
    endtask

    task automatic cycle_b(input logic en_val, input string tag);
        en_b = en_val;
        @(posedge clk);
        if (rst_b && en_val) model_step();
        @(negedge clk);
        check_obs(tag, obs_b(), model_b());
    endtask

    task automatic step_a(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    function automatic obs_t exp_a(input logic [10:0] h, input logic [10:0] v, input logic hs,
                                   input logic hb, input logic [23:0] pat);
        obs_t o;
        o = '0;
        o.h = h; o.v = v; o.hs = hs; o.hb = hb; o.bl = hb;
        o.rgb = PAT_ON ? pat : 24'h0;
        return o;
    endfunction

    initial begin
        vec_t vecs[$];
        obs_t hold_exp;
        int   cur;
        int   pulses;

        rst_a = 1'b0; en_a = 1'b1;
        rst_b = 1'b0; en_b = 1'b1;
        model_reset();

        // Default raster, first line and the start of the second, from reset.
        vecs.push_back('{1,    11'd1,    11'd0, 1'b0, 1'b0, 24'hFFFFFF});
        vecs.push_back('{100,  11'd100,  11'd0, 1'b0, 1'b0, 24'hFFFF00});
        vecs.push_back('{250,  11'd250,  11'd0, 1'b0, 1'b0, 24'h00FFFF});
        vecs.push_back('{750,  11'd750,  11'd0, 1'b0, 1'b0, 24'h000000});
        vecs.push_back('{799,  11'd799,  11'd0, 1'b0, 1'b0, 24'h000000});
        vecs.push_back('{800,  11'd800,  11'd0, 1'b0, 1'b1, 24'h000000});
        vecs.push_back('{839,  11'd839,  11'd0, 1'b0, 1'b1, 24'h000000});
        vecs.push_back('{840,  11'd840,  11'd0, 1'b1, 1'b1, 24'h000000});
        vecs.push_back('{967,  11'd967,  11'd0, 1'b1, 1'b1, 24'h000000});
        vecs.push_back('{968,  11'd968,  11'd0, 1'b0, 1'b1, 24'h000000});
        vecs.push_back('{1055, 11'd1055, 11'd0, 1'b0, 1'b1, 24'h000000});
        vecs.push_back('{1056, 11'd0,    11'd1, 1'b0, 1'b0, 24'hFFFFFF});
        vecs.push_back('{1057, 11'd1,    11'd1, 1'b0, 1'b0, 24'hFFFFFF});

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_obs("reset_a", obs_a(), '0);
        check_obs("reset_b", obs_b(), model_b());

        rst_a = 1'b1;
        cur = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            step_a(vecs[i].adv - cur);
            cur = vecs[i].adv;
            check_obs($sformatf("vec%0d_h%0d", i, vecs[i].h), obs_a(),
                      exp_a(vecs[i].h, vecs[i].v, vecs[i].hs, vecs[i].hb, vecs[i].pat));
        end

        // Enable gating just before the sync pulse.
        step_a(1056 + 839 - cur);
        hold_exp = exp_a(11'd839, 11'd1, 1'b0, 1'b1, 24'h0);
        check_obs("gate_pre", obs_a(), hold_exp);
        en_a = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step_a(1);
            check_obs("gate_hold", obs_a(), hold_exp);
        end
        en_a = 1'b1;
        step_a(1);
        check_obs("gate_resume", obs_a(), exp_a(11'd840, 11'd1, 1'b1, 1'b1, 24'h0));

        // Asynchronous reset between edges, then restart from (0,0).
        rst_a = 1'b0;
        #1;
        check_obs("areset_a", obs_a(), '0);
        @(negedge clk);
        rst_a = 1'b1;
        step_a(1);
        check_obs("restart_a", obs_a(), exp_a(11'd1, 11'd0, 1'b0, 1'b0, 24'hFFFFFF));

        // Small raster: one full frame plus two cycles.
        rst_b = 1'b1;
        pulses = 0;
        for (int i = 0; i < BTOT + 2; i++) begin
            cycle_b(1'b1, "frame_b");
            if (b_frame_start === 1'b1) pulses++;
        end
        check("frame_b_pulses", 32'(pulses), 32'd1);
        check("frame_b_cnt", 32'(b_frame_cnt), 32'd1);

        // A frame_start pulse must survive disabled cycles.
        for (int i = 0; i < BTOT && m_p != 0; i++) cycle_b(1'b1, "seek_b");
        check("seek_b_fs", 32'(b_frame_start), 32'd1);
        for (int i = 0; i < 3; i++) cycle_b(1'b0, "fs_hold_b");
        check("fs_hold_b_end", 32'(b_frame_start), 32'd1);

        // Mid-frame asynchronous reset.
        for (int i = 0; i < BTOT && m_p != 5 * BHT + 7; i++) cycle_b(1'b1, "seek_mid_b");
        check("seek_mid_b_v", 32'(b_vcount), 32'd5);
        rst_b = 1'b0;
        #1;
        model_reset();
        check_obs("areset_b", obs_b(), model_b());
        @(negedge clk);
        cycle_b(1'b1, "held_b");
        rst_b = 1'b1;

        // Random enable with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_b = 1'b0;
                #1;
                model_reset();
                check_obs("rand_areset_b", obs_b(), model_b());
                @(negedge clk);
                rst_b = 1'b1;
            end
            cycle_b(($urandom_range(0, 3) != 0), "rand_b");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator; first stage of the video pipeline.
- Produces pixel coordinates, hsync, vsync and blanking for the drawing stages.
- Its sync, blank and rgb streams pass through the drawing stages and feed the negedge output register that drives the Basys3 VGA pins.
- Defaults give 800x600@60 Hz at a 40 MHz pixel clock.

Parameters:
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync pulse width (pixels)
- H_BACK, 88, horizontal back porch (pixels); H_TOTAL = sum = 1056
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines); V_TOTAL = sum = 628
- SYNC_POL, 1, active level of hsync/vsync (1 = active-high)

Ports:
- clk  input  1  pixel clock, all logic on posedge
- rst  input  1  asynchronous, active-low reset (reset while 0)
- en  input  1  count enable; 0 freezes all state
- hcount  output  11  current pixel column, 0..H_TOTAL-1
- vcount  output  11  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, polarity SYNC_POL
- vsync  output  1  vertical sync, polarity SYNC_POL
- hblnk  output  1  1 when hcount >= H_VISIBLE
- vblnk  output  1  1 when vcount >= V_VISIBLE
- blnk  output  1  hblnk OR vblnk
- frame_start  output  1  one-cycle pulse when position returns to (0,0)
- frame_cnt  output  16  frames completed, wraps modulo 2^16
- rgb  output  24  test-pattern pixel {R,G,B}; 0 when feature absent

Behaviour:
- Reset (rst=0, async):
  - hcount=0, vcount=0, hblnk=0, vblnk=0, blnk=0.
  - hsync=vsync=~SYNC_POL.
  - frame_start=0, frame_cnt=0, rgb=0.
- All outputs are registers. Sync, blank, frame_start and rgb are computed from the next count values, so every output describes the same position as hcount/vcount on the same cycle. Zero skew between fields.
- Counting, per posedge with en=1:
  - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 only on a line wrap.
- en=0: every register holds its value, including frame_start. A pulse in progress stays high until the next enabled edge.
- hsync active iff H_VISIBLE+H_FRONT <= hcount < H_VISIBLE+H_FRONT+H_SYNC (defaults 840..967).
- vsync active iff V_VISIBLE+V_FRONT <= vcount < V_VISIBLE+V_FRONT+V_SYNC (defaults 601..604).
  - vsync changes together with the hcount 0 transition of the qualifying line.
- frame_start:
  - 1 for exactly one enabled cycle, the one where (hcount,vcount) becomes (0,0) after a wrap.
  - Not asserted at the reset position before the first wrap.
- frame_cnt increments on the same edge that asserts frame_start. Wraps 65535 -> 0 silently.
- Reset mid-frame: immediate return to reset values. Counting resumes from (0,0) on the first enabled edge after rst=1, so the first increment gives hcount=1.
- Widths: 11-bit counters cover H_TOTAL and V_TOTAL up to 2048. Parameters exceeding this are illegal; checked by a simulation-only assertion.

Optional Feature:
- Macro: VGA_TEST_PATTERN_EN.
- Defined:
  - rgb shows 8 vertical colour bars of width H_VISIBLE/8. Bar index = hcount/100 at defaults.
  - Order: white, yellow, cyan, green, magenta, red, blue, black. Each component is 8'hFF or 8'h00.
  - rgb is forced to 0 whenever the registered blnk is 1. Same alignment as the other outputs.
- Undefined: the rgb register and bar logic are not instantiated; rgb is tied to 24'h000000.

Test Plan:
- Reset: hold rst=0 for 5 cycles with en=1 -> hcount=vcount=0, hsync=vsync=0, blnk=0, frame_cnt=0. After rst=1, first edge gives hcount=1.
- Line timing: run one line from reset ->
  - hblnk rises at hcount=800.
  - hsync=1 exactly for hcount 840..967 (128 cycles).
  - Wrap at 1055 -> 0 with vcount 0 -> 1.
- Frame timing: run 1056*628 cycles ->
  - vsync=1 for vcount 601..604.
  - vblnk=1 for vcount 600..627.
  - frame_start single pulse at (0,0).
  - frame_cnt=1.
- Enable gating: drop en for 10 cycles at hcount=839 -> hcount, hsync and all others frozen. Resuming gives hcount=840 with hsync=1.
- Async reset mid-frame: assert rst=0 between edges at vcount=300 -> outputs return to reset values without waiting for clk. frame_cnt=0.
- With VGA_TEST_PATTERN_EN: rgb=24'hFFFFFF at hcount=0, 24'hFFFF00 at hcount=100, 24'h000000 at hcount=750 and at any blnk=1 position. Without the macro, rgb=0 at all times.
